matmul_seq_ctrl: RTL and testbench

- Fetch-redirect controller for the MATMUL2 microcode mode. It sits between the decode stage and the PC/instruction-memory mux in the pipelined core.
- Detects STARTMATMUL2 and ENDMATMUL in decode, saves the return PC, and redirects fetch to the microcode ROM base.
- Drives im_sel to the matmul instruction memory, restores PC on exit, and raises pipeline flush requests.
- Provides fsm_state, im_sel, save_pc, toggle_fsm and pc_backup to the top level and the matmul bench.

---
 rtl/matmul_pkg.sv | 16 +
 rtl/matmul_decode.sv | 19 +
 rtl/matmul_seq_ctrl.sv | 130 +++++++++++++
 tb/tb_matmul_seq_ctrl.sv | 229 ++++++++++++++++++++++
 4 files changed

// File: rtl/matmul_pkg.sv
// Shared types and encodings for the MATMUL2 fetch-redirect controller.
package matmul_pkg;

   typedef enum logic [1:0] {
      S_IDLE  = 2'd0,
      S_ENTER = 2'd1,
      S_RUN   = 2'd2,
      S_EXIT  = 2'd3
   } state_t;

   localparam logic [6:0]  OP_MATMUL          = 7'b1111010;
   localparam logic [2:0]  F3_START           = 3'b000;
   localparam logic [2:0]  F3_END             = 3'b111;
   localparam logic [31:0] UCODE_BASE_DEFAULT = 32'h0000_0000;

endpackage

// File: rtl/matmul_decode.sv
// Combinational STARTMATMUL2 / ENDMATMUL detector, shared with the hazard unit.
module matmul_decode import matmul_pkg::*; #(
   parameter int XLEN = 32
) (
   input  logic [XLEN-1:0] instr_i,
   output logic            is_start_o,
   output logic            is_end_o
);

   logic is_op;
   logic unused_bits;

   assign is_op      = (instr_i[6:0] == OP_MATMUL);
   assign is_start_o = is_op && (instr_i[14:12] == F3_START);
   assign is_end_o   = is_op && (instr_i[14:12] == F3_END);

   assign unused_bits = ^{instr_i[XLEN-1:15], instr_i[11:7]};

endmodule

// File: rtl/matmul_seq_ctrl.sv
// MATMUL2 fetch-redirect FSM: enter/exit microcode mode, save/restore the return PC.
// Optional RUN-state watchdog enabled by defining MATMUL_WDOG_EN.
module matmul_seq_ctrl import matmul_pkg::*; #(
   parameter int              XLEN        = 32,
   parameter logic [XLEN-1:0] UCODE_BASE  = XLEN'(UCODE_BASE_DEFAULT),
   parameter int              CNT_W       = 16,
   parameter int              WDOG_CYCLES = 1024
) (
   input  logic             clk,
   input  logic             reset,
   input  logic [XLEN-1:0]  InstrD,
   input  logic [XLEN-1:0]  PCPlus4D,
   input  logic             StallD,
   output logic             toggle_fsm,
   output logic             save_pc,
   output logic             fsm_state,
   output logic             im_sel,
   output logic             redirect,
   output logic [XLEN-1:0]  redirect_pc,
   output logic             flush,
   output logic [XLEN-1:0]  pc_backup,
   output logic [CNT_W-1:0] uop_count,
`ifdef MATMUL_WDOG_EN
   output logic             wdog_hit,
`endif
   output logic             seq_err
);

   state_t             state_q, state_d;
   logic [XLEN-1:0]    pc_backup_q, pc_backup_d;
   logic [CNT_W-1:0]   uop_count_q, uop_count_d;
   logic               seq_err_q, seq_err_d;
   logic               is_start, is_end;
   logic               start_acc, end_acc;

   matmul_decode #(.XLEN(XLEN)) u_decode (
      .instr_i    (InstrD),
      .is_start_o (is_start),
      .is_end_o   (is_end)
   );

   assign start_acc = (state_q == S_IDLE) && is_start && !StallD;
   assign end_acc   = (state_q == S_RUN)  && is_end   && !StallD;

`ifdef MATMUL_WDOG_EN
   localparam int WD_W = $clog2(WDOG_CYCLES + 1);
   logic [WD_W-1:0] wdog_q, wdog_d;
   logic            wdog_expire;

   // A same-cycle END wins over the timeout and is treated as a clean exit.
   assign wdog_expire = (state_q == S_RUN) && (wdog_q == WD_W'(WDOG_CYCLES - 1)) && !end_acc;
   assign wdog_hit    = wdog_expire && !reset;

   always_comb begin
      wdog_d = wdog_q;
      if (state_q == S_ENTER)    wdog_d = '0;
      else if (state_q == S_RUN) wdog_d = wdog_q + 1'b1;
   end

   always_ff @(posedge clk) begin
      if (reset) wdog_q <= '0;
      else       wdog_q <= wdog_d;
   end
`endif

   always_comb begin
      state_d     = state_q;
      pc_backup_d = pc_backup_q;
      uop_count_d = uop_count_q;
      seq_err_d   = seq_err_q;
      case (state_q)
         S_IDLE: begin
            if (start_acc) begin
               state_d     = S_ENTER;
               pc_backup_d = PCPlus4D;
               uop_count_d = '0;
            end else if (is_end && !StallD) begin
               seq_err_d = 1'b1;
            end
         end
         S_ENTER: state_d = S_RUN;
         S_RUN: begin
            if (end_acc) begin
               state_d = S_EXIT;
            end else begin
`ifdef MATMUL_WDOG_EN
               if (wdog_expire) begin
                  state_d   = S_EXIT;
                  seq_err_d = 1'b1;
               end
`endif
               // A nested START is rejected and is not a microcode instruction.
               if (!StallD) begin
                  if (is_start)               seq_err_d   = 1'b1;
                  else if (uop_count_q != '1) uop_count_d = uop_count_q + 1'b1;
               end
            end
         end
         S_EXIT:  state_d = S_IDLE;
         default: state_d = S_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q     <= S_IDLE;
         pc_backup_q <= '0;
         uop_count_q <= '0;
         seq_err_q   <= 1'b0;
      end else begin
         state_q     <= state_d;
         pc_backup_q <= pc_backup_d;
         uop_count_q <= uop_count_d;
         seq_err_q   <= seq_err_d;
      end
   end

   assign toggle_fsm  = (start_acc || end_acc) && !reset;
   assign save_pc     = start_acc && !reset;
   assign fsm_state   = (state_q != S_IDLE);
   assign im_sel      = (state_q == S_ENTER) || (state_q == S_RUN);
   assign redirect    = (state_q == S_ENTER) || (state_q == S_EXIT);
   assign flush       = redirect;
   assign redirect_pc = (state_q == S_ENTER) ? UCODE_BASE :
                        (state_q == S_EXIT)  ? pc_backup_q : '0;
   assign pc_backup   = pc_backup_q;
   assign uop_count   = uop_count_q;
   assign seq_err     = seq_err_q;

endmodule

// File: tb/tb_matmul_seq_ctrl.sv
// Scoreboard bench for matmul_seq_ctrl; define MATMUL_WDOG_EN to also exercise the watchdog.
module tb_matmul_seq_ctrl;

   localparam int XLEN  = 32;
   localparam int CNT_W = 16;
   localparam logic [31:0] I_START = 32'h0000_007A;
   localparam logic [31:0] I_END   = 32'h0000_707A;
   localparam logic [31:0] I_OTHER = 32'h0000_207A;
   localparam logic [31:0] I_NOP   = 32'h0000_0013;

   logic             clk = 1'b0;
   logic             reset = 1'b1;
   logic [XLEN-1:0]  InstrD = I_NOP;
   logic [XLEN-1:0]  PCPlus4D = '0;
   logic             StallD = 1'b0;
   logic             toggle_fsm, save_pc, fsm_state, im_sel, redirect, flush, seq_err;
   logic [XLEN-1:0]  redirect_pc, pc_backup;
   logic [CNT_W-1:0] uop_count;
`ifdef MATMUL_WDOG_EN
   logic             wdog_hit;
`endif

   int n_tests = 0;
   int n_fail  = 0;

   typedef struct {
      logic [31:0] pc;
      logic        im;
   } redir_t;
   redir_t redir_q[$];
   logic   tog_q[$];

   always #5 clk = ~clk;

   matmul_seq_ctrl #(
      .XLEN(XLEN), .UCODE_BASE(32'h0000_0000), .CNT_W(CNT_W), .WDOG_CYCLES(8)
   ) dut (
      .clk(clk), .reset(reset), .InstrD(InstrD), .PCPlus4D(PCPlus4D), .StallD(StallD),
      .toggle_fsm(toggle_fsm), .save_pc(save_pc), .fsm_state(fsm_state), .im_sel(im_sel),
      .redirect(redirect), .redirect_pc(redirect_pc), .flush(flush), .pc_backup(pc_backup),
      .uop_count(uop_count),
`ifdef MATMUL_WDOG_EN
      .wdog_hit(wdog_hit),
`endif
      .seq_err(seq_err)
   );

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   task automatic drive(input logic r, input logic [31:0] ins, input logic [31:0] pc4, input logic st);
      @(posedge clk);
      #1;
      reset    = r;
      InstrD   = ins;
      PCPlus4D = pc4;
      StallD   = st;
      @(negedge clk);
   endtask

   task automatic expect_start();
      tog_q.push_back(1'b1);
      redir_q.push_back('{pc: 32'h0, im: 1'b1});
   endtask

   task automatic expect_end(input logic [31:0] ret_pc);
      tog_q.push_back(1'b0);
      redir_q.push_back('{pc: ret_pc, im: 1'b0});
   endtask

   // Monitor: pops the scoreboard whenever the DUT presents a toggle or redirect.
   always @(negedge clk) begin
      if (reset === 1'b0) begin
         if (toggle_fsm === 1'b1) begin
            if (tog_q.size() == 0) begin
               n_tests++; n_fail++;
               $display("FAIL unexpected_toggle: got toggle_fsm=1 save_pc=%b expected no toggle", save_pc);
            end else begin
               logic exp_save;
               exp_save = tog_q.pop_front();
               chk("toggle_save_pc", {31'h0, save_pc}, {31'h0, exp_save});
            end
         end else if (save_pc !== 1'b0) begin
            chk("save_pc_without_toggle", {31'h0, save_pc}, 32'h0);
         end
         if (redirect === 1'b1) begin
            if (redir_q.size() == 0) begin
               n_tests++; n_fail++;
               $display("FAIL unexpected_redirect: got redirect_pc=%h expected no redirect", redirect_pc);
            end else begin
               redir_t e;
               e = redir_q.pop_front();
               chk("redirect_pc", redirect_pc, e.pc);
               chk("redirect_im_sel", {31'h0, im_sel}, {31'h0, e.im});
               chk("redirect_flush", {31'h0, flush}, 32'h1);
            end
         end else if (flush !== 1'b0) begin
            chk("flush_without_redirect", {31'h0, flush}, 32'h0);
         end
      end
   end

   initial begin
      #200000;
      $display("FAIL timeout: got no finish expected finish within budget");
      $fatal(1, "timeout");
   end

   initial begin
      // Reset state
      drive(1'b1, I_NOP, 32'h0, 1'b0);
      drive(1'b1, I_NOP, 32'h0, 1'b0);
      drive(1'b0, I_NOP, 32'h0, 1'b0);
      chk("rst_fsm_state", {31'h0, fsm_state}, 32'h0);
      chk("rst_im_sel", {31'h0, im_sel}, 32'h0);
      chk("rst_redirect", {31'h0, redirect}, 32'h0);
      chk("rst_toggle", {31'h0, toggle_fsm}, 32'h0);
      chk("rst_seq_err", {31'h0, seq_err}, 32'h0);
      chk("rst_pc_backup", pc_backup, 32'h0);
      chk("rst_uop_count", {16'h0, uop_count}, 32'h0);
      chk("rst_redirect_pc", redirect_pc, 32'h0);

      // Basic entry, five microcode instructions, exit
      expect_start();
      drive(1'b0, I_START, 32'h24, 1'b0);
      drive(1'b0, I_NOP, 32'h0, 1'b0);
      chk("enter_pc_backup", pc_backup, 32'h24);
      chk("enter_fsm_state", {31'h0, fsm_state}, 32'h1);
      drive(1'b0, I_NOP, 32'h0, 1'b0);
      drive(1'b0, I_OTHER, 32'h0, 1'b0);
      drive(1'b0, I_NOP, 32'h0, 1'b1);
      drive(1'b0, I_NOP, 32'h0, 1'b0);
      drive(1'b0, I_NOP, 32'h0, 1'b0);
      drive(1'b0, I_NOP, 32'h0, 1'b0);
      expect_end(32'h24);
      drive(1'b0, I_END, 32'h0, 1'b0);
      chk("run_uop_count", {16'h0, uop_count}, 32'd5);
      drive(1'b0, I_NOP, 32'h0, 1'b0);
      chk("exit_fsm_state", {31'h0, fsm_state}, 32'h1);
      drive(1'b0, I_NOP, 32'h0, 1'b0);
      chk("idle_fsm_state", {31'h0, fsm_state}, 32'h0);
      chk("idle_uop_hold", {16'h0, uop_count}, 32'd5);
      chk("idle_pc_backup_hold", pc_backup, 32'h24);

      // START held under stall for three cycles
      for (int i = 0; i < 3; i++) begin
         drive(1'b0, I_START, 32'h40, 1'b1);
         chk("stall_no_toggle", {31'h0, toggle_fsm}, 32'h0);
      end
      chk("stall_pc_backup_kept", pc_backup, 32'h24);
      expect_start();
      drive(1'b0, I_START, 32'h40, 1'b0);
      drive(1'b0, I_NOP, 32'h0, 1'b0);
      chk("stall_pc_backup_set", pc_backup, 32'h40);
      drive(1'b0, I_NOP, 32'h0, 1'b0);
      chk("stall_run_im_sel", {31'h0, im_sel}, 32'h1);

      // Reset in RUN
      drive(1'b1, I_NOP, 32'h0, 1'b0);
      drive(1'b0, I_NOP, 32'h0, 1'b0);
      chk("midrst_im_sel", {31'h0, im_sel}, 32'h0);
      chk("midrst_fsm_state", {31'h0, fsm_state}, 32'h0);
      chk("midrst_pc_backup", pc_backup, 32'h0);
      chk("midrst_uop_count", {16'h0, uop_count}, 32'h0);
      chk("midrst_redirect", {31'h0, redirect}, 32'h0);

      // Nested START in RUN is rejected
      expect_start();
      drive(1'b0, I_START, 32'h50, 1'b0);
      drive(1'b0, I_NOP, 32'h0, 1'b0);
      drive(1'b0, I_START, 32'h99, 1'b0);
      chk("nest_no_toggle", {31'h0, toggle_fsm}, 32'h0);
      drive(1'b0, I_NOP, 32'h0, 1'b0);
      chk("nest_seq_err", {31'h0, seq_err}, 32'h1);
      chk("nest_stay_run", {31'h0, im_sel}, 32'h1);
      chk("nest_pc_backup", pc_backup, 32'h50);
      chk("nest_not_counted", {16'h0, uop_count}, 32'h0);
      expect_end(32'h50);
      drive(1'b0, I_END, 32'h0, 1'b0);
      drive(1'b0, I_NOP, 32'h0, 1'b0);
      drive(1'b0, I_NOP, 32'h0, 1'b0);
      chk("nest_uop_after", {16'h0, uop_count}, 32'h1);
      chk("nest_back_idle", {31'h0, fsm_state}, 32'h0);

`ifdef MATMUL_WDOG_EN
      begin
         int hit;
         hit = -1;
         drive(1'b1, I_NOP, 32'h0, 1'b0);
         expect_start();
         drive(1'b0, I_START, 32'h60, 1'b0);
         drive(1'b0, I_NOP, 32'h0, 1'b0);
         redir_q.push_back('{pc: 32'h60, im: 1'b0});
         for (int i = 0; i < 16 && hit < 0; i++) begin
            drive(1'b0, I_NOP, 32'h0, 1'b0);
            if (wdog_hit === 1'b1) hit = i;
         end
         chk("wdog_hit_cycle", hit, 32'd7);
         drive(1'b0, I_NOP, 32'h0, 1'b0);
         chk("wdog_exit_hit_cleared", {31'h0, wdog_hit}, 32'h0);
         drive(1'b0, I_NOP, 32'h0, 1'b0);
         chk("wdog_seq_err", {31'h0, seq_err}, 32'h1);
         chk("wdog_idle", {31'h0, fsm_state}, 32'h0);
      end
`endif

      // END in IDLE
      drive(1'b1, I_NOP, 32'h0, 1'b0);
      drive(1'b0, I_END, 32'h0, 1'b0);
      chk("idle_end_no_toggle", {31'h0, toggle_fsm}, 32'h0);
      drive(1'b0, I_NOP, 32'h0, 1'b0);
      chk("idle_end_seq_err", {31'h0, seq_err}, 32'h1);
      chk("idle_end_no_redirect", {31'h0, redirect}, 32'h0);
      chk("idle_end_fsm_state", {31'h0, fsm_state}, 32'h0);
      drive(1'b0, I_NOP, 32'h0, 1'b0);

      chk("scoreboard_toggle_drained", tog_q.size(), 32'h0);
      chk("scoreboard_redirect_drained", redir_q.size(), 32'h0);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
